// File: rtl/mem_access_unit_pkg.sv
// +----------------------------------------------------------------------+
// | mem_access_unit_pkg : size encodings, FSM states, alignment helper   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package mem_access_unit_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_READ     = 2'd1,
        ST_LOAD_RET = 2'd2,
        ST_WRITE    = 2'd3
    } state_t;

    // True for a misaligned access or the reserved size code.
    function automatic logic bad_access(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = off[0];
            SIZE_WORD: bad = (off != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_byte_lane.sv
// +----------------------------------------------------------------------+
// | mem_byte_lane : load lane extract/extend and sub-word store merge    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_byte_lane
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wr_data_i,
    output logic [31:0] load_o,
    output logic [31:0] merged_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte   = word_i[{offset_i, 3'b000} +: 8];
        w_half   = offset_i[1] ? word_i[31:16] : word_i[15:0];
        load_o   = word_i;
        merged_o = word_i;
        case (size_i)
            SIZE_BYTE: begin
                load_o = {{24{~unsigned_i & w_byte[7]}}, w_byte};
                merged_o[{offset_i, 3'b000} +: 8] = wr_data_i[7:0];
            end
            SIZE_HALF: begin
                load_o = {{16{~unsigned_i & w_half[15]}}, w_half};
                if (offset_i[1]) begin
                    merged_o[31:16] = wr_data_i[15:0];
                end else begin
                    merged_o[15:0] = wr_data_i[15:0];
                end
            end
            default: begin
                load_o   = word_i;
                merged_o = wr_data_i;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// +----------------------------------------------------------------------+
// | mem_access_unit : MEM-stage load/store sequencer with sub-word RMW   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_ADDR_SIZE = 5,
    parameter int BYTE_ADDR_SIZE = 32,
    parameter int WORD_SIZE      = 32
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_flush,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic                      i_mem_read,
    input  logic                      i_mem_write,
    input  logic [1:0]                i_size,
    input  logic                      i_unsigned,
    input  logic [BYTE_ADDR_SIZE-1:0] i_addr,
    input  logic [WORD_SIZE-1:0]      i_wr_data,
    output logic [WORD_SIZE-1:0]      o_rd_data,
    output logic                      o_done,
    output logic                      o_error,
    output logic                      o_busy,
    output logic                      o_mem_wr_rd,
    output logic [DATA_ADDR_SIZE-1:0] o_mem_addr,
    output logic [WORD_SIZE-1:0]      o_mem_data,
    input  logic [WORD_SIZE-1:0]      i_mem_data
);

    state_t                    state_q, state_d;
    logic [DATA_ADDR_SIZE-1:0] addr_q;
    logic [1:0]                off_q;
    logic [1:0]                size_q;
    logic                      uns_q;
    logic                      store_q;
    logic [WORD_SIZE-1:0]      wdata_q;
    logic [WORD_SIZE-1:0]      rword_q;
    logic [WORD_SIZE-1:0]      rd_data_q;
    logic                      err_q;

    logic                      w_accept;
    logic                      w_bad;
    logic [WORD_SIZE-1:0]      w_lane_word;
    logic [WORD_SIZE-1:0]      w_load_val;
    logic [WORD_SIZE-1:0]      w_merged;
    logic [BYTE_ADDR_SIZE-DATA_ADDR_SIZE-3:0] w_unused_addr;

    assign w_unused_addr = i_addr[BYTE_ADDR_SIZE-1:DATA_ADDR_SIZE+2];

    assign w_accept = (state_q == ST_IDLE) && i_valid && (i_mem_read || i_mem_write) && !i_flush;
    assign w_bad    = bad_access(i_size, i_addr[1:0]) || (i_mem_read && i_mem_write);

    // The lane extracts from live memory data while reading, and merges from the captured word while writing.
    assign w_lane_word = (state_q == ST_WRITE) ? rword_q : i_mem_data;

    mem_byte_lane u_lane (
        .offset_i   (off_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .word_i     (w_lane_word),
        .wr_data_i  (wdata_q),
        .load_o     (w_load_val),
        .merged_o   (w_merged)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept && !w_bad) begin
                    state_d = (i_mem_write && i_size == SIZE_WORD) ? ST_WRITE : ST_READ;
                end
            end
            ST_READ:     state_d = store_q ? ST_WRITE : ST_LOAD_RET;
            ST_LOAD_RET: state_d = ST_IDLE;
            ST_WRITE:    state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
        if (i_flush) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            off_q     <= '0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            store_q   <= 1'b0;
            wdata_q   <= '0;
            rword_q   <= '0;
            rd_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= w_accept && w_bad;
            if (w_accept && !w_bad) begin
                addr_q  <= i_addr[DATA_ADDR_SIZE+1:2];
                off_q   <= i_addr[1:0];
                size_q  <= i_size;
                uns_q   <= i_unsigned;
                store_q <= i_mem_write;
                wdata_q <= i_wr_data;
            end
            if (state_q == ST_READ && !i_flush) begin
                rword_q <= i_mem_data;
                if (!store_q) begin
                    rd_data_q <= w_load_val;
                end
            end
        end
    end

    assign o_ready     = (state_q == ST_IDLE);
    assign o_busy      = !o_ready;
    assign o_done      = ((state_q == ST_LOAD_RET) || (state_q == ST_WRITE)) && !i_flush;
    assign o_error     = err_q;
    assign o_rd_data   = rd_data_q;
    assign o_mem_wr_rd = (state_q == ST_WRITE) && !i_flush;
    assign o_mem_addr  = addr_q;
    assign o_mem_data  = (state_q == ST_WRITE) ? w_merged : '0;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// +----------------------------------------------------------------------+
// | tb_mem_access_unit : directed + random bench against a byte model    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mem_access_unit;

    logic        i_clk = 1'b0;
    logic        i_reset, i_flush, i_valid, i_mem_read, i_mem_write, i_unsigned;
    logic [1:0]  i_size;
    logic [31:0] i_addr, i_wr_data, i_mem_data;
    logic        o_ready, o_done, o_error, o_busy, o_mem_wr_rd;
    logic [31:0] o_rd_data, o_mem_data;
    logic [4:0]  o_mem_addr;

    logic [31:0] mem   [0:31];
    logic [7:0]  ref_b [0:127];
    logic [31:0] exp_rd;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 i_clk = ~i_clk;

    mem_access_unit dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_flush     (i_flush),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_mem_read  (i_mem_read),
        .i_mem_write (i_mem_write),
        .i_size      (i_size),
        .i_unsigned  (i_unsigned),
        .i_addr      (i_addr),
        .i_wr_data   (i_wr_data),
        .o_rd_data   (o_rd_data),
        .o_done      (o_done),
        .o_error     (o_error),
        .o_busy      (o_busy),
        .o_mem_wr_rd (o_mem_wr_rd),
        .o_mem_addr  (o_mem_addr),
        .o_mem_data  (o_mem_data),
        .i_mem_data  (i_mem_data)
    );

    // Word-addressed data memory: combinational read, write on negedge.
    assign i_mem_data = mem[o_mem_addr];
    always @(negedge i_clk) begin
        if (o_mem_wr_rd) mem[o_mem_addr] <= o_mem_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int w);
        return {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input bit uns, input int ba);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = 32'(ref_b[ba]);
            if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = 32'(ref_b[ba]) + 32'(ref_b[ba+1]) * 256;
            if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = ref_word(ba / 4);
        end
        return v;
    endfunction

    task automatic scramble_inputs();
        i_mem_read  = 1'($urandom);
        i_mem_write = 1'($urandom);
        i_size      = 2'($urandom);
        i_unsigned  = 1'($urandom);
        i_addr      = $urandom;
        i_wr_data   = $urandom;
    endtask

    // Issue one request (called #1 after a posedge) and check it against the model.
    task automatic do_op(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] wd);
        int          ba, nbytes, done_at, err_at, n_done;
        bit          ignored, err, saw_wr, saw_busy;
        logic [31:0] t;
        ba      = int'(a[6:0]);
        ignored = !rd && !wr;
        err     = !ignored && (sz == 2'd3 || (sz == 2'd1 && a[0]) ||
                               (sz == 2'd2 && a[1:0] != 2'b00) || (rd && wr));
        i_valid = 1'b1; i_mem_read = rd; i_mem_write = wr; i_size = sz;
        i_unsigned = uns; i_addr = a; i_wr_data = wd;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        scramble_inputs();
        done_at = 0; err_at = 0; n_done = 0; saw_wr = 0; saw_busy = 0;
        for (int c = 1; c <= 4; c++) begin
            if (o_done) begin n_done++; if (done_at == 0) done_at = c; end
            if (o_error && err_at == 0) err_at = c;
            if (o_mem_wr_rd) saw_wr = 1;
            if (!o_ready) saw_busy = 1;
            @(posedge i_clk); #1;
        end
        if (ignored) begin
            check("ign_done", 32'(done_at), 32'd0);
            check("ign_err", 32'(err_at), 32'd0);
        end else if (err) begin
            check("err_lat", 32'(err_at), 32'd1);
            check("err_done", 32'(done_at), 32'd0);
            check("err_wr", 32'(saw_wr), 32'd0);
            check("err_busy", 32'(saw_busy), 32'd0);
        end else if (rd) begin
            exp_rd = ref_load(sz, uns, ba);
            check("ld_lat", 32'(done_at), 32'd2);
            check("ld_wr", 32'(saw_wr), 32'd0);
        end else begin
            nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
            for (int k = 0; k < nbytes; k++) begin
                t = wd >> (8 * k);
                ref_b[ba + k] = t[7:0];
            end
            check("st_lat", 32'(done_at), (sz == 2'd2) ? 32'd1 : 32'd2);
            check("st_wr", 32'(saw_wr), 32'd1);
        end
        if (!ignored && !err) check("done_cnt", 32'(n_done), 32'd1);
        check("rd_data", o_rd_data, exp_rd);
        check("ready", 32'(o_ready), 32'd1);
        check("mem_word", mem[ba / 4], ref_word(ba / 4));
    endtask

    initial begin
        int sel, n_done;
        logic [1:0]  sz;
        logic [31:0] a, r;

        i_reset = 1'b0; i_flush = 1'b0; i_valid = 1'b0;
        scramble_inputs();
        exp_rd = '0;
        for (int w = 0; w < 32; w++) begin
            r = $urandom;
            mem[w] = r;
            for (int k = 0; k < 4; k++) begin
                a = r >> (8 * k);
                ref_b[4*w + k] = a[7:0];
            end
        end
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_outs", {o_rd_data | o_mem_data}, 32'd0);
        check("rst_flags", {27'd0, o_mem_addr} | 32'({o_done, o_error, o_mem_wr_rd}), 32'd0);
        i_reset = 1'b1;
        @(posedge i_clk); #1;

        // Word round trip, byte merge, halfword.
        do_op(0, 1, 2'd2, 0, 32'h8, 32'hDEADBEEF);
        check("sw_word2", mem[2], 32'hDEADBEEF);
        do_op(1, 0, 2'd2, 0, 32'h8, 32'h0);
        check("lw_val", o_rd_data, 32'hDEADBEEF);
        do_op(0, 1, 2'd0, 0, 32'hA, 32'h1234_5655);
        check("sb_merge", mem[2], 32'hDE55BEEF);
        do_op(1, 0, 2'd0, 0, 32'hB, 32'h0);
        check("lb_val", o_rd_data, 32'hFFFFFFDE);
        do_op(1, 0, 2'd0, 1, 32'hB, 32'h0);
        check("lbu_val", o_rd_data, 32'h000000DE);
        do_op(0, 1, 2'd1, 0, 32'h6, 32'hABCD_8001);
        check("sh_upper", 32'(mem[1][31:16]), 32'h8001);
        do_op(1, 0, 2'd1, 0, 32'h6, 32'h0);
        check("lh_val", o_rd_data, 32'hFFFF8001);
        do_op(1, 0, 2'd1, 1, 32'h6, 32'h0);
        check("lhu_val", o_rd_data, 32'h00008001);

        // Error cases and an ignored request.
        do_op(1, 0, 2'd2, 0, 32'h5, 32'h0);
        do_op(1, 0, 2'd1, 0, 32'h3, 32'h0);
        do_op(1, 0, 2'd3, 0, 32'h8, 32'h0);
        do_op(1, 1, 2'd2, 0, 32'h8, 32'h0);
        do_op(0, 0, 2'd2, 0, 32'h8, 32'h0);

        // Flush during the WRITE cycle of a byte store.
        i_valid = 1'b1; i_mem_read = 0; i_mem_write = 1; i_size = 2'd0;
        i_unsigned = 0; i_addr = 32'h11; i_wr_data = 32'hAA;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        @(posedge i_clk); #1;
        i_flush = 1'b1; #1;
        check("flush_wr", 32'(o_mem_wr_rd), 32'd0);
        check("flush_done", 32'(o_done), 32'd0);
        @(posedge i_clk); #1;
        i_flush = 1'b0;
        check("flush_ready", 32'(o_ready), 32'd1);
        check("flush_mem", mem[4], ref_word(4));
        check("flush_rd", o_rd_data, exp_rd);

        // Reset asserted during READ of a load.
        i_valid = 1'b1; i_mem_read = 1; i_mem_write = 0; i_size = 2'd2; i_addr = 32'h8;
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_reset = 1'b0;
        @(posedge i_clk); #1;
        exp_rd = '0;
        check("rrd_ready", 32'(o_ready), 32'd1);
        check("rrd_outs", o_rd_data | o_mem_data, 32'd0);
        check("rrd_flags", {27'd0, o_mem_addr} | 32'({o_done, o_error, o_mem_wr_rd}), 32'd0);
        i_reset = 1'b1;
        @(posedge i_clk); #1;

        // Request held while busy must be taken once.
        i_valid = 1'b1; i_mem_read = 1; i_mem_write = 0; i_size = 2'd2;
        i_unsigned = 0; i_addr = 32'h4; n_done = 0;
        @(posedge i_clk); #1;
        for (int c = 0; c < 6; c++) begin
            if (o_done) begin n_done++; i_valid = 1'b0; end
            @(posedge i_clk); #1;
        end
        i_valid = 1'b0;
        exp_rd = ref_word(1);
        check("hold_done", 32'(n_done), 32'd1);
        check("hold_rd", o_rd_data, exp_rd);

        // Random traffic, mostly legal and aligned.
        for (int n = 0; n < 150; n++) begin
            sel = $urandom_range(0, 9);
            sz  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a   = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            do_op(sel <= 3 || sel == 8, (sel >= 4 && sel <= 7) || sel == 8,
                  sz, 1'($urandom), a, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
